bcd_hex_display_driver: RTL

BCD_HEX_DISPLAY_DRIVER -- requirements
Module: bcd_hex_display_driver

---
 rtl/bcd_hex_display_driver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bcd_hex_display_driver.sv
// bcd_hex_display_driver
//
// Converts a packed BCD value into active-low seven-segment patterns for
// DISPLAY_DIGITS displays. Optionally suppresses leading zeros. Digits are
// decoded one per clock into a shadow register. The visible segments are
// updated in one step, so a partially converted value is never shown.
//
// Ports
//   clock             : single clock, rising edge
//   reset             : synchronous, active-high
//   bcdValue          : packed BCD input, digit i in bits [4i+3:4i]
//   load              : start a conversion (honoured only when idle)
//   blankLeadingZeros : leading-zero suppression, sampled with load
//   segments          : active-low segments, display i in bits [7i+6:7i],
//                       a..g = bit0..bit6
//   busy              : conversion in progress
//   done              : one-cycle pulse when segments first shows a new result
//   digitError        : the last committed value contained a nibble > 9
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for load; outputs hold
// SCAN   | decoding one digit per clock, MSD first, into the shadow
// COMMIT | shadow -> segments, error flag -> digitError, pulse done

module bcd_hex_display_driver #(
    parameter int DISPLAY_DIGITS = 6,
    parameter int BCD_BITWIDTH   = DISPLAY_DIGITS * 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [BCD_BITWIDTH-1:0]       bcdValue,
    input  logic                          load,
    input  logic                          blankLeadingZeros,
    output logic [7*DISPLAY_DIGITS-1:0]   segments,
    output logic                          busy,
    output logic                          done,
    output logic                          digitError
);

    localparam int SEG_W = 7 * DISPLAY_DIGITS;
    localparam int IDX_W = (DISPLAY_DIGITS > 1) ? $clog2(DISPLAY_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DISPLAY_DIGITS - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [BCD_BITWIDTH-1:0]  value_q, value_d;
    logic [IDX_W-1:0]         digit_idx_q, digit_idx_d;
    logic                     suppress_q, suppress_d;
    logic                     err_acc_q, err_acc_d;
    logic [SEG_W-1:0]         shadow_q, shadow_d;
    logic [SEG_W-1:0]         segments_q, segments_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     digit_error_q, digit_error_d;

    logic [3:0]               cur_digit;
    logic [6:0]               cur_seg;

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d       = state_q;
        value_d       = value_q;
        digit_idx_d   = digit_idx_q;
        suppress_d    = suppress_q;
        err_acc_d     = err_acc_q;
        shadow_d      = shadow_q;
        segments_d    = segments_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        digit_error_d = digit_error_q;

        cur_digit = value_q[int'(digit_idx_q) * 4 +: 4];
        cur_seg   = decode_digit(cur_digit);

        case (state_q)
            IDLE: begin
                if (load) begin
                    value_d     = bcdValue;
                    digit_idx_d = LAST_IDX;
                    suppress_d  = blankLeadingZeros;
                    err_acc_d   = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SCAN;
                end
            end

            SCAN: begin
                if (cur_digit > 4'd9) begin
                    // An invalid nibble counts as significant: it ends blanking.
                    err_acc_d  = 1'b1;
                    suppress_d = 1'b0;
                end else if (suppress_q && (cur_digit == 4'd0) && (digit_idx_q != '0)) begin
                    cur_seg = SEG_BLANK;
                end else if (cur_digit != 4'd0) begin
                    suppress_d = 1'b0;
                end
                shadow_d[int'(digit_idx_q) * 7 +: 7] = cur_seg;

                if (digit_idx_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    digit_idx_d = digit_idx_q - 1'b1;
                end
            end

            COMMIT: begin
                segments_d    = shadow_q;
                digit_error_d = err_acc_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            value_q       <= '0;
            digit_idx_q   <= '0;
            suppress_q    <= 1'b0;
            err_acc_q     <= 1'b0;
            shadow_q      <= {DISPLAY_DIGITS{SEG_BLANK}};
            segments_q    <= {DISPLAY_DIGITS{SEG_BLANK}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            digit_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            digit_idx_q   <= digit_idx_d;
            suppress_q    <= suppress_d;
            err_acc_q     <= err_acc_d;
            shadow_q      <= shadow_d;
            segments_q    <= segments_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            digit_error_q <= digit_error_d;
        end
    end

    assign segments   = segments_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign digitError = digit_error_q;

endmodule
